// File: rtl/recorder_ctrl.sv
// recorder_ctrl: record/playback sequencer that owns the single SRAM request port.
// Optional RECORDER_LOOP_EN: playback wraps from word end_addr-1 back to word 0.
module recorder_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record_btn,
  input  logic              play_btn,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              dac_req,
  output logic              dac_valid,
  output logic [DATA_W-1:0] dac_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              recording,
  output logic              playing,
  output logic [ADDR_W-1:0] end_addr,
  output logic              overrun,
  output logic              underrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECORD,
    S_PLAY
  } state_t;

  // Largest whole number of frames that fits in the address space.
  localparam int              CAP_INT = ((1 << ADDR_W) / NUM_CH) * NUM_CH;
  localparam logic [ADDR_W:0] CAP     = (ADDR_W + 1)'(CAP_INT);
  localparam logic [1:0]      LAST_CH = 2'(NUM_CH - 1);

  state_t              state_q, state_d;
  logic                rec_sync_q, rec_sync_d;
  logic                rec_prev_q, rec_prev_d;
  logic                play_sync_q, play_sync_d;
  logic                play_prev_q, play_prev_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [1:0]          ch_cnt_q, ch_cnt_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
  logic                overrun_q, overrun_d;
  logic                underrun_q, underrun_d;
  logic                stop_pend_q, stop_pend_d;
  logic                play_stop_q, play_stop_d;
  logic                dac_valid_q, dac_valid_d;
  logic [DATA_W-1:0]   dac_data_q, dac_data_d;

  logic rec_rise;
  logic play_rise;
  logic ack_ok;
  logic slot_free;
  logic last_word;

  assign rec_rise  = rec_sync_q & ~rec_prev_q;
  assign play_rise = play_sync_q & ~play_prev_q;
  assign ack_ok    = mem_ack & mem_req_q;
  assign slot_free = ~mem_req_q | ack_ok;
  assign last_word = (rd_ptr_q + 1'b1) == end_addr_q;

  always_comb begin
    state_d     = state_q;
    rec_sync_d  = record_btn;
    rec_prev_d  = rec_sync_q;
    play_sync_d = play_btn;
    play_prev_d = play_sync_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_ptr_d    = wr_ptr_q;
    ch_cnt_d    = ch_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    end_addr_d  = end_addr_q;
    overrun_d   = overrun_q;
    underrun_d  = underrun_q;
    stop_pend_d = stop_pend_q;
    play_stop_d = play_stop_q;
    dac_valid_d = 1'b0;
    dac_data_d  = dac_data_q;

    if (ack_ok) begin
      mem_req_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rec_rise) begin
          state_d     = S_RECORD;
          wr_ptr_d    = '0;
          ch_cnt_d    = '0;
          overrun_d   = 1'b0;
          underrun_d  = 1'b0;
          stop_pend_d = 1'b0;
          hold_full_d = 1'b0;
        end else if (play_rise && end_addr_q != '0) begin
          state_d     = S_PLAY;
          rd_ptr_d    = '0;
          underrun_d  = 1'b0;
          play_stop_d = 1'b0;
        end
      end

      S_RECORD: begin
        if (rec_rise) begin
          stop_pend_d = 1'b1;
        end
        if (ack_ok) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          ch_cnt_d = (ch_cnt_q == LAST_CH) ? 2'd0 : ch_cnt_q + 2'd1;
        end

        // A stop request only takes effect on a frame boundary with the bus quiet.
        if (ack_ok && wr_ptr_d == CAP) begin
          state_d     = S_IDLE;
          end_addr_d  = wr_ptr_d[ADDR_W-1:0];
          hold_full_d = 1'b0;
        end else if ((stop_pend_q || rec_rise) && !mem_req_q && !hold_full_q &&
                     ch_cnt_q == 2'd0) begin
          state_d    = S_IDLE;
          end_addr_d = wr_ptr_q[ADDR_W-1:0];
        end else begin
          if (slot_free && hold_full_q) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_d[ADDR_W-1:0];
            mem_wdata_d = hold_data_q;
            hold_full_d = 1'b0;
          end
          if (sample_valid) begin
            if (slot_free && !hold_full_q) begin
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = wr_ptr_d[ADDR_W-1:0];
              mem_wdata_d = sample_data;
            end else if (!hold_full_d) begin
              hold_full_d = 1'b1;
              hold_data_d = sample_data;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end

      S_PLAY: begin
        // A stop waits for any outstanding read and discards its data.
        if (play_rise || play_stop_q) begin
          if (slot_free) begin
            state_d     = S_IDLE;
            play_stop_d = 1'b0;
          end else begin
            play_stop_d = 1'b1;
          end
        end else begin
          if (ack_ok) begin
            dac_valid_d = 1'b1;
            dac_data_d  = mem_rdata;
`ifdef RECORDER_LOOP_EN
            rd_ptr_d = last_word ? '0 : rd_ptr_q + 1'b1;
`else
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (last_word) begin
              state_d = S_IDLE;
            end
`endif
          end
          if (dac_req && state_d == S_PLAY) begin
            if (slot_free) begin
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = rd_ptr_d;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rec_sync_q  <= 1'b0;
      rec_prev_q  <= 1'b0;
      play_sync_q <= 1'b0;
      play_prev_q <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ptr_q    <= '0;
      ch_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      end_addr_q  <= '0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      stop_pend_q <= 1'b0;
      play_stop_q <= 1'b0;
      dac_valid_q <= 1'b0;
      dac_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rec_sync_q  <= rec_sync_d;
      rec_prev_q  <= rec_prev_d;
      play_sync_q <= play_sync_d;
      play_prev_q <= play_prev_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      ch_cnt_q    <= ch_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      end_addr_q  <= end_addr_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      stop_pend_q <= stop_pend_d;
      play_stop_q <= play_stop_d;
      dac_valid_q <= dac_valid_d;
      dac_data_q  <= dac_data_d;
    end
  end

  assign dac_valid = dac_valid_q;
  assign dac_data  = dac_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign recording = (state_q == S_RECORD);
  assign playing   = (state_q == S_PLAY);
  assign end_addr  = end_addr_q;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;

endmodule
